sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's `sync_fifo`. It adds:
- configurable data width and depth;
- a selectable first-word-fall-through (FWFT) read mode;
- programmable almost-full / almost-empty thresholds and an occupancy count;
- separate sticky overflow/underflow status with software clear.

It sits between a producer and a consumer in the same clock domain and is the buffering primitive for the next round of datapath blocks and their testbenches.

## Interface
- `WIDTH`, 16, data word width in bits (≥1).
- `DEPTH`, 16, number of entries; must be a power of two, ≥2.
- `AF_LEVEL`, DEPTH-2, `almost_full_o` asserts when level ≥ AF_LEVEL (1..DEPTH).
- `AE_LEVEL`, 2, `almost_empty_o` asserts when level ≤ AE_LEVEL (0..DEPTH-1).
- `FWFT`, 0, 0 = standard registered read, 1 = first-word-fall-through.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `wdata_i`  in  WIDTH  write data.
- `wr_en_i`  in  1  write request.
- `rd_en_i`  in  1  read request (pop).
- `err_clr_i`  in  1  clears sticky overflow/underflow.
- `rdata_o`  out  WIDTH  read data.
- `rvalid_o`  out  1  `rdata_o` valid.
- `empty_o`  out  1  level == 0.
- `full_o`  out  1  level == DEPTH.
- `almost_full_o`  out  1  level ≥ AF_LEVEL.
- `almost_empty_o`  out  1  level ≤ AE_LEVEL.
- `level_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow_o`  out  1  sticky: write attempted while full.
- `underflow_o`  out  1  sticky: read attempted while empty.
- `error_o`  out  1  `overflow_o | underflow_o`.

## Operation
- **Storage and pointers**
  - Storage is DEPTH×WIDTH.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - `level_o` is a registered counter.
- **Accept rules** use the flags as registered at the start of the cycle:
  - write accepted = `wr_en_i & !full_o`;
  - read accepted = `rd_en_i & !empty_o`.
- **Write while full:**
  - no write occurs, even if a read is accepted the same cycle;
  - `overflow_o` sets;
  - the pointer and level are unchanged by the write.
- **Read while empty:**
  - no pop occurs;
  - `underflow_o` sets;
  - `rdata_o` holds its value.
- **Level update:**
  - +1 on an accepted write only;
  - −1 on an accepted read only;
  - unchanged when both are accepted or neither is.
- **Flags** are pure decodes of the registered level (no combinational path from inputs).
- **Standard mode (FWFT=0):**
  - an accepted read registers mem[rd_ptr] into `rdata_o`;
  - `rvalid_o` pulses high for exactly that following cycle;
  - `rdata_o` holds its last value otherwise.
- **FWFT mode (FWFT=1):**
  - `rdata_o` = mem[rd_ptr] combinationally;
  - `rvalid_o` = `!empty_o`;
  - `rd_en_i` acknowledges and pops the displayed word.
- **Sticky errors:**
  - `err_clr_i` clears `overflow_o` and `underflow_o`;
  - if a new error event occurs in the same cycle as `err_clr_i`, set wins.
- **Reset** (`rst_i` low at a rising edge), regardless of in-flight operations:
  - pointers = 0, `level_o` = 0;
  - `empty_o` = 1, `almost_empty_o` = 1;
  - `full_o` = 0, `almost_full_o` = 0;
  - `rvalid_o` = 0, `rdata_o` = 0 (standard mode);
  - `overflow_o` = 0, `underflow_o` = 0, `error_o` = 0;
  - memory contents are not cleared.

## Timing
- **Write to visibility:** a write accepted at edge N makes `level_o`, `empty_o` and `full_o` reflect it after edge N.
  - FWFT: a word written into an empty FIFO at edge N is on `rdata_o` with `rvalid_o`=1 in cycle N+1 (1-cycle latency).
  - Standard: a read requested in cycle N+1 gives data after edge N+1 (2-cycle write-to-data).
- **Read latency:** standard mode is 1 cycle from accepted `rd_en_i` to `rvalid_o`/`rdata_o`.
- **Back-to-back operation:** one write and one read per cycle are sustainable indefinitely at any level 1..DEPTH-1.
- **Error timing:** `overflow_o` and `underflow_o` assert the cycle after the offending edge.
- **Reset release:** the first accepted write is in the first cycle with `rst_i` high.

## Test plan
- **Reset values:** hold `rst_i` low 2 cycles mid-traffic (level 7) → next cycle `level_o`=0, `empty_o`=1, `rvalid_o`=0, `error_o`=0; old data never reappears on `rdata_o`.
- **Fill/overflow (DEPTH=16, AF_LEVEL=14):** write 0x0000..0x000F on consecutive cycles.
  - `almost_full_o` rises after the 14th write; `full_o` and `level_o`=16 after the 16th.
  - A 17th write with a simultaneous read → `overflow_o`=1, `level_o`=15, and data 0x0000 is read.
- **Drain/underflow (AE_LEVEL=2):** read all 16 words.
  - Data comes out in order 0x0000..0x000F with `rvalid_o` one cycle after each read.
  - `almost_empty_o` rises when level reaches 2.
  - An extra read when empty → `underflow_o`=1 and `rdata_o` holds 0x000F.
- **Wrap and concurrency:** hold level at 5, then do simultaneous read+write for 40 cycles → `level_o` stays 5, and the output sequence equals the input sequence delayed by 5 across pointer wrap.
- **FWFT=1:**
  - write 0xABCD into an empty FIFO → the next cycle `rdata_o`=0xABCD, `rvalid_o`=1 with no `rd_en_i`;
  - `rd_en_i` pops it → `empty_o`=1 the following cycle.
- **Error clear:**
  - assert `err_clr_i` while overflowed → `error_o`=0 next cycle;
  - assert `err_clr_i` together with a new write-while-full → `overflow_o` stays 1.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with FWFT option, level flags, occupancy count and sticky overflow/underflow
module sync_fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     wr_en_i,
  input  logic                     rd_en_i,
  input  logic                     err_clr_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     rvalid_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic                     error_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic rvalid_q, rvalid_d, ovf_q, ovf_d, udf_q, udf_d, wr_acc, rd_acc;
  assign empty_o        = level_q == '0;
  assign full_o         = level_q == LW'(DEPTH);
  assign almost_full_o  = level_q >= LW'(AF_LEVEL);
  assign almost_empty_o = level_q <= LW'(AE_LEVEL);
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign error_o        = ovf_q | udf_q;
  assign rdata_o        = FWFT != 0 ? mem_q[rd_ptr_q] : rdata_q;
  assign rvalid_o       = FWFT != 0 ? !empty_o : rvalid_q;
  always_comb begin
    wr_acc   = wr_en_i & !full_o;
    rd_acc   = rd_en_i & !empty_o;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = (wr_acc & !rd_acc) ? level_q + LW'(1) :
               (rd_acc & !wr_acc) ? level_q - LW'(1) : level_q;
    rdata_d  = (rd_acc && FWFT == 0) ? mem_q[rd_ptr_q] : rdata_q;
    rvalid_d = rd_acc && FWFT == 0;
    ovf_d    = (wr_en_i & full_o) | (ovf_q & !err_clr_i);
    udf_d    = (rd_en_i & empty_o) | (udf_q & !err_clr_i);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i && wr_acc) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule
